// File: rtl/alu_datapath.sv
// alu_datapath: registered 8-bit, seven-operation ALU with a 2-bit control FSM.
// The operands A/B are captured from num1/num2 under in_sel control. The
// result `out` is a one-hot out_sel pick among the operation results on the
// stored operands. currState/nextState are exported for monitoring.
module alu_datapath (
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [2:0] in_sel,
  input  logic [7:0] num1,
  input  logic [7:0] num2,
  input  logic [6:0] out_sel,
  output logic [7:0] out,
  output logic [1:0] currState,
  output logic [1:0] nextState
);

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_CLEAR = 2'b01;
  localparam logic [1:0] ST_LOAD  = 2'b10;
  localparam logic [1:0] ST_HOLD  = 2'b11;

  localparam logic [6:0] SEL_ADD = 7'b1000000;
  localparam logic [6:0] SEL_SUB = 7'b0100000;
  localparam logic [6:0] SEL_MUL = 7'b0010000;
  localparam logic [6:0] SEL_AND = 7'b0001000;
  localparam logic [6:0] SEL_OR  = 7'b0000100;
  localparam logic [6:0] SEL_XOR = 7'b0000010;
  localparam logic [6:0] SEL_NOT = 7'b0000001;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic [7:0] out_d;

  // Operation results; all 8-bit so carries, borrows and high product bits drop.
  logic [7:0] add_s;
  logic [7:0] sub_s;
  logic [7:0] mul_s;

  assign add_s = a_q + b_q;
  assign sub_s = a_q - b_q;
  assign mul_s = a_q * b_q;

  // State register: reset forces OFF, otherwise follow the next-state logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: enable first, then clear > load > persist/idle.
  always_comb begin
    state_d = ST_HOLD;
    if (!on) begin
      state_d = ST_OFF;
    end else if (in_sel[0]) begin
      state_d = ST_CLEAR;
    end else if (in_sel[1]) begin
      state_d = ST_LOAD;
    end else begin
      state_d = ST_HOLD;
    end
  end

  // Operand registers: load or clear according to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 8'd0;
      b_q <= 8'd0;
    end else begin
      case (state_d)
        ST_LOAD: begin
          a_q <= num1;
          b_q <= num2;
        end
        ST_CLEAR: begin
          a_q <= 8'd0;
          b_q <= 8'd0;
        end
        default: begin
          a_q <= a_q;
          b_q <= b_q;
        end
      endcase
    end
  end

  // Output logic: zero when OFF or when out_sel is not exactly one-hot.
  always_comb begin
    out_d = 8'd0;
    if (state_q == ST_OFF) begin
      out_d = 8'd0;
    end else begin
      case (out_sel)
        SEL_ADD: out_d = add_s;
        SEL_SUB: out_d = sub_s;
        SEL_MUL: out_d = mul_s;
        SEL_AND: out_d = a_q & b_q;
        SEL_OR:  out_d = a_q | b_q;
        SEL_XOR: out_d = a_q ^ b_q;
        SEL_NOT: out_d = ~a_q;
        default: out_d = 8'd0;
      endcase
    end
  end

  assign out       = out_d;
  assign currState = state_q;
  assign nextState = state_d;

endmodule

// File: tb/tb_alu_datapath.sv
// tb_alu_datapath: directed plus randomized checks of alu_datapath against a
// behavioural model built from plain integer arithmetic.
module tb_alu_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       on = 1'b0;
  logic [2:0] in_sel = 3'd0;
  logic [7:0] num1 = 8'd0;
  logic [7:0] num2 = 8'd0;
  logic [6:0] out_sel = 7'd0;
  logic [7:0] out;
  logic [1:0] currState;
  logic [1:0] nextState;

  int checks = 0;
  int errors = 0;

  // Model state: 0 OFF, 1 CLEAR, 2 LOAD, 3 HOLD; operands as plain integers.
  int m_state = 0;
  int m_a = 0;
  int m_b = 0;

  alu_datapath dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .out_sel(out_sel), .out(out), .currState(currState), .nextState(nextState)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  function automatic int m_next();
    if (on !== 1'b1) return 0;
    if (in_sel[0]) return 1;
    if (in_sel[1]) return 2;
    return 3;
  endfunction

  function automatic int m_out();
    if (m_state == 0) return 0;
    if ($countones(out_sel) != 1) return 0;
    if (out_sel[6]) return (m_a + m_b) % 256;
    if (out_sel[5]) return (m_a - m_b + 256) % 256;
    if (out_sel[4]) return (m_a * m_b) % 256;
    if (out_sel[3]) return m_a & m_b;
    if (out_sel[2]) return m_a | m_b;
    if (out_sel[1]) return m_a ^ m_b;
    return 255 - m_a;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One rising edge; the model advances with the inputs held before the edge.
  task automatic tick();
    int n;
    n = m_next();
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_a = 0; m_b = 0;
    end else begin
      if (n == 2) begin
        m_a = num1; m_b = num2;
      end else if (n == 1) begin
        m_a = 0; m_b = 0;
      end
      m_state = n;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cs"}, {6'd0, currState}, 8'(m_state));
    chk({tag, "_ns"}, {6'd0, nextState}, 8'(m_next()));
    chk({tag, "_out"}, out, 8'(m_out()));
  endtask

  logic [6:0] sel_tab [6];
  logic [7:0] exp_tab [6];

  initial begin
    sel_tab = '{7'b0100000, 7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010, 7'b0000001};
    exp_tab = '{8'd61, 8'd214, 8'd18, 8'd95, 8'd77, 8'd168};

    // Reset phase
    rst = 1'b1;
    #12;
    chk("rst_cs", {6'd0, currState}, 8'd0);
    chk("rst_out", out, 8'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_cs", {6'd0, currState}, 8'd0);
    chk("post_rst_out", out, 8'd0);
    on = 1'b1; in_sel = 3'b010; #1;
    chk("ns_load", {6'd0, nextState}, 8'd2);

    // LOAD 87/26 and sweep every operation combinationally
    num1 = 8'd87; num2 = 8'd26; out_sel = 7'b1000000;
    tick();
    chk("load_cs", {6'd0, currState}, 8'd2);
    chk("add_87_26", out, 8'd113);
    for (int i = 0; i < 6; i++) begin
      out_sel = sel_tab[i]; #1;
      chk($sformatf("op_%0d", i), out, exp_tab[i]);
      chk($sformatf("op_model_%0d", i), out, 8'(m_out()));
    end

    // LOAD 2/4 then persist with changed num1
    num1 = 8'd2; num2 = 8'd4; out_sel = 7'b1000000;
    tick();
    chk("add_2_4", out, 8'd6);
    in_sel = 3'b100; num1 = 8'd255;
    tick();
    chk("hold_out", out, 8'd6);
    chk("hold_cs", {6'd0, currState}, 8'd3);

    // Wrap cases
    in_sel = 3'b010; num1 = 8'd200; num2 = 8'd100;
    tick();
    chk("add_wrap", out, 8'd44);
    num1 = 8'd4; num2 = 8'd6; out_sel = 7'b0100000;
    tick();
    chk("sub_wrap", out, 8'd254);
    num1 = 8'd16; num2 = 8'd16; out_sel = 7'b0010000;
    tick();
    chk("mul_wrap", out, 8'd0);
    out_sel = 7'b1000000; #1;
    chk("add_16_16", out, 8'd32);

    // Multi-hot in_sel: clear wins
    in_sel = 3'b011;
    tick();
    chk("clr_cs", {6'd0, currState}, 8'd1);
    chk("clr_add", out, 8'd0);
    out_sel = 7'b0000001; #1;
    chk("clr_not", out, 8'd255);
    out_sel = 7'b0000100; #1;
    chk("clr_or", out, 8'd0);

    // Non-one-hot out_sel
    in_sel = 3'b010; num1 = 8'd5; num2 = 8'd3; out_sel = 7'b1000000;
    tick();
    chk("add_5_3", out, 8'd8);
    out_sel = 7'b1100000; #1;
    chk("multi_sel", out, 8'd0);
    out_sel = 7'b0000000; #1;
    chk("zero_sel", out, 8'd0);

    // on=0 then restore with persist
    out_sel = 7'b1000000; on = 1'b0;
    tick();
    chk("off_cs", {6'd0, currState}, 8'd0);
    chk("off_out", out, 8'd0);
    on = 1'b1; in_sel = 3'b100;
    tick();
    chk("resume_cs", {6'd0, currState}, 8'd3);
    chk("resume_out", out, 8'd8);

    // Asynchronous reset mid-cycle after a LOAD
    in_sel = 3'b010; num1 = 8'd9; num2 = 8'd9;
    tick();
    chk("pre_rst_out", out, 8'd18);
    #2; rst = 1'b1; #1;
    m_state = 0; m_a = 0; m_b = 0;
    chk("async_rst_out", out, 8'd0);
    chk("async_rst_cs", {6'd0, currState}, 8'd0);
    chk("async_rst_ns", {6'd0, nextState}, 8'd2);
    // Reset held across an edge with LOAD requested: reset wins
    tick();
    chk("rst_edge_cs", {6'd0, currState}, 8'd0);
    rst = 1'b0; in_sel = 3'b100;
    tick();
    chk("rst_edge_hold_cs", {6'd0, currState}, 8'd3);
    chk("rst_edge_out", out, 8'd0);

    // Randomized stimulus against the model
    for (int i = 0; i < 300; i++) begin
      on = ($urandom_range(0, 7) != 0);
      in_sel = 3'($urandom);
      num1 = 8'($urandom);
      num2 = 8'($urandom);
      if ($urandom_range(0, 1) == 0) out_sel = 7'(1 << $urandom_range(0, 6));
      else out_sel = 7'($urandom);
      #1;
      chk("rnd_ns_pre", {6'd0, nextState}, 8'(m_next()));
      tick();
      check_model("rnd");
      out_sel = 7'(1 << $urandom_range(0, 6));
      num1 = 8'($urandom);
      #1;
      chk("rnd_sel_change", out, 8'(m_out()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
